eth_txarb_rr: RTL



---
 rtl/eth_txarb_rr_if.sv | 23 ++
 rtl/eth_txarb_rr.sv | 119 +++++++++++
 2 files changed

// File: rtl/eth_txarb_rr_if.sv
// Input-FIFO read ports and output-FIFO write port of the round-robin TX arbiter.
// master = arbiter side, slave = FIFO side.
interface eth_txarb_rr_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ENTRY_W = 74
);
    logic [NUM_CH-1:0]         fifo_rd_en;
    logic [NUM_CH*ENTRY_W-1:0] fifo_dout;
    logic [NUM_CH-1:0]         fifo_empty;
    logic                      wr_en;
    logic [ENTRY_W-1:0]        din;
    logic                      full;

    modport master (
        output fifo_rd_en, wr_en, din,
        input  fifo_dout, fifo_empty, full
    );

    modport slave (
        input  fifo_rd_en, wr_en, din,
        output fifo_dout, fifo_empty, full
    );
endinterface

// File: rtl/eth_txarb_rr.sv
// Packet-atomic round-robin arbiter: merges NUM_CH FWFT TLP FIFOs into one output
// FIFO write port, one IDLE bubble per packet, zero-latency head-to-output datapath.
module eth_txarb_rr #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ENTRY_W = DATA_W + DATA_W/8 + 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk156,
    input  logic                    sys_rst,
    input  logic [NUM_CH-1:0]       ch_en,
    eth_txarb_rr_if.master          fifo_if,
    output logic [CH_W-1:0]         grant_ch,
    output logic                    busy,
    output logic [NUM_CH*CNT_W-1:0] pkt_cnt
);
    localparam int unsigned TLAST_BIT = ENTRY_W - 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    grant_ch_q, grant_ch_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   pkt_cnt_q [NUM_CH];
    logic [CNT_W-1:0]   pkt_cnt_d [NUM_CH];

    logic [ENTRY_W-1:0] head [NUM_CH];
    logic [NUM_CH-1:0]  req;
    logic               sel_found;
    logic [CH_W-1:0]    sel_ch;
    logic [CH_W-1:0]    cand;
    logic               pop_c;
    logic               last_c;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign head[g]                   = fifo_if.fifo_dout[g*ENTRY_W +: ENTRY_W];
        assign pkt_cnt[g*CNT_W +: CNT_W] = pkt_cnt_q[g];
    end

    assign req      = ch_en & ~fifo_if.fifo_empty;
    assign pop_c    = (state_q == XFER) && !fifo_if.fifo_empty[grant_ch_q] && !fifo_if.full;
    assign last_c   = head[grant_ch_q][TLAST_BIT];
    assign grant_ch = grant_ch_q;

    // Round-robin search starting just after the last-served channel.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            grant_ch_q <= '0;
            rr_ptr_q   <= CH_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_ch_q <= grant_ch_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    // Next state: grant in IDLE, release only once the tlast beat has been popped.
    always_comb begin
        state_d    = state_q;
        grant_ch_d = grant_ch_q;
        rr_ptr_d   = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
        end
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_ch_d = sel_ch;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (pop_c && last_c) begin
                    state_d               = IDLE;
                    rr_ptr_d              = grant_ch_q;
                    pkt_cnt_d[grant_ch_q] = pkt_cnt_q[grant_ch_q] + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pop and write are the same strobe, gated by the downstream full flag.
    always_comb begin
        fifo_if.fifo_rd_en = '0;
        fifo_if.wr_en      = 1'b0;
        fifo_if.din        = head[grant_ch_q];
        busy               = 1'b0;
        if (state_q == XFER) begin
            busy                           = 1'b1;
            fifo_if.wr_en                  = pop_c;
            fifo_if.fifo_rd_en[grant_ch_q] = pop_c;
        end
    end
endmodule
